// File: rtl/rbe_column_accumulator_pkg.sv
// rbe_column_accumulator_pkg
// Shared types for the column accumulator slice. It holds the control/flag
// bundles, the accumulator FSM state encoding and the widths that the top and
// the index counter must agree on.
package rbe_column_accumulator_pkg;

    localparam int unsigned CTRL_CNT_WIDTH = 16;
    localparam int unsigned SHIFT_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_OUT = 2'd2
    } accum_state_e;

    typedef struct packed {
        logic [2:0]                qa_m1;
        logic [2:0]                qw_m1;
        logic [CTRL_CNT_WIDTH-1:0] n_kin;
        logic [CTRL_CNT_WIDTH-1:0] n_out;
        logic                      start;
    } ctrl_column_accumulator_t;

    typedef struct packed {
        logic         busy;
        logic         done;
        accum_state_e state;
    } flags_column_accumulator_t;

endpackage

// File: rtl/rbe_column_accumulator_if.sv
// rbe_column_accumulator_if
// Valid/ready stream bundle (hwpe-stream style) used for the partial-result
// input and the accumulated-pixel output of the column accumulator.
//   valid/ready : handshake, transfer when both are high on a clock edge
//   data        : DATA_WIDTH payload
//   strb        : byte strobes, one per 8 data bits
// master drives valid/data/strb, slave drives ready.
interface rbe_column_accumulator_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);

endinterface

// File: rtl/rbe_accum_idx_counter.sv
// rbe_accum_idx_counter
// Nested beat counter of the column accumulator. Fastest first:
// w_idx 0..QW-1, a_idx 0..QA-1, kin_idx 0..N_KIN-1, out_idx 0..N_OUT-1.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   clear_i           : synchronous clear of counters and latched config
//   load_i            : latch qa/qw/n_kin/n_out and zero all counters
//   advance_i         : step the nest by one beat (a pres handshake)
//   first_beat_o      : current beat is the first of a pixel
//   last_beat_o       : current beat is the last of a pixel
//   last_job_o        : current beat is the last of the whole job
//   shift_o           : a_idx + w_idx, the bit weight of the current beat
module rbe_accum_idx_counter
    import rbe_column_accumulator_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CTRL_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic                   advance_i,
    input  logic [2:0]             qa_m1_i,
    input  logic [2:0]             qw_m1_i,
    input  logic [CNT_WIDTH-1:0]   n_kin_i,
    input  logic [CNT_WIDTH-1:0]   n_out_i,
    output logic                   first_beat_o,
    output logic                   last_beat_o,
    output logic                   last_job_o,
    output logic [SHIFT_WIDTH-1:0] shift_o
);

    logic [2:0]           w_q, w_d, a_q, a_d, qa_max_q, qa_max_d, qw_max_q, qw_max_d;
    logic [CNT_WIDTH-1:0] kin_q, kin_d, out_q, out_d;
    logic [CNT_WIDTH-1:0] kin_max_q, kin_max_d, out_max_q, out_max_d;
    logic                 last_w, last_a, last_kin;

    assign last_w       = (w_q == qw_max_q);
    assign last_a       = (a_q == qa_max_q);
    assign last_kin     = (kin_q == kin_max_q);
    assign first_beat_o = (w_q == 3'd0) && (a_q == 3'd0) && (kin_q == '0);
    assign last_beat_o  = last_w && last_a && last_kin;
    assign last_job_o   = last_beat_o && (out_q == out_max_q);
    assign shift_o      = {1'b0, a_q} + {1'b0, w_q};

    // Counts of zero are stored as a maximum index of zero, i.e. treated as 1.
    always_comb begin
        w_d       = w_q;
        a_d       = a_q;
        kin_d     = kin_q;
        out_d     = out_q;
        qa_max_d  = qa_max_q;
        qw_max_d  = qw_max_q;
        kin_max_d = kin_max_q;
        out_max_d = out_max_q;
        if (load_i) begin
            w_d       = '0;
            a_d       = '0;
            kin_d     = '0;
            out_d     = '0;
            qa_max_d  = qa_m1_i;
            qw_max_d  = qw_m1_i;
            kin_max_d = (n_kin_i == '0) ? '0 : n_kin_i - CNT_WIDTH'(1);
            out_max_d = (n_out_i == '0) ? '0 : n_out_i - CNT_WIDTH'(1);
        end else if (advance_i) begin
            w_d = last_w ? 3'd0 : w_q + 3'd1;
            if (last_w) begin
                a_d = last_a ? 3'd0 : a_q + 3'd1;
            end
            if (last_w && last_a) begin
                kin_d = last_kin ? '0 : kin_q + CNT_WIDTH'(1);
            end
            if (last_beat_o) begin
                out_d = last_job_o ? '0 : out_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q       <= '0;
            a_q       <= '0;
            kin_q     <= '0;
            out_q     <= '0;
            qa_max_q  <= '0;
            qw_max_q  <= '0;
            kin_max_q <= '0;
            out_max_q <= '0;
        end else if (clear_i) begin
            w_q       <= '0;
            a_q       <= '0;
            kin_q     <= '0;
            out_q     <= '0;
            qa_max_q  <= '0;
            qw_max_q  <= '0;
            kin_max_q <= '0;
            out_max_q <= '0;
        end else begin
            w_q       <= w_d;
            a_q       <= a_d;
            kin_q     <= kin_d;
            out_q     <= out_d;
            qa_max_q  <= qa_max_d;
            qw_max_q  <= qw_max_d;
            kin_max_q <= kin_max_d;
            out_max_q <= out_max_d;
        end
    end

endmodule

// File: rtl/rbe_column_accumulator.sv
// rbe_column_accumulator
// Bit-serial shift-and-add over the partial-result stream of one BinConv
// column. Each output pixel is the wrapped sum of QA*QW*N_KIN beats,
// each shifted left by a_idx + w_idx.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   clear_i              : synchronous clear, same effect as reset
//   enable_i             : 0 freezes the input side
//   start_i              : begin a job (honoured in IDLE only)
//   qa_m1_i, qw_m1_i     : activation / weight bits minus one
//   n_kin_i, n_out_i     : beats-of-kin per pixel, pixels per job (0 -> 1)
//   pres_i               : column partial results (strb ignored)
//   accum_o              : accumulated pixel results, one holding register
//   busy_o               : job in progress (ACCUM or WAIT_OUT)
//   done_o               : one-cycle pulse after the last result is taken
module rbe_column_accumulator
    import rbe_column_accumulator_pkg::*;
#(
    parameter int unsigned PRES_WIDTH = 46,
    parameter int unsigned ACC_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH  = CTRL_CNT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic                     start_i,
    input  logic [2:0]               qa_m1_i,
    input  logic [2:0]               qw_m1_i,
    input  logic [CNT_WIDTH-1:0]     n_kin_i,
    input  logic [CNT_WIDTH-1:0]     n_out_i,
    rbe_column_accumulator_if.slave  pres_i,
    rbe_column_accumulator_if.master accum_o,
    output logic                     busy_o,
    output logic                     done_o
);

    ctrl_column_accumulator_t  ctrl;
    flags_column_accumulator_t flags_q;

    logic                   pres_ready, pres_hs, load;
    logic                   first_beat, last_beat, last_job;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [ACC_WIDTH-1:0]   shifted, sum;
    logic [ACC_WIDTH-1:0]   acc_q, out_data_q;
    logic                   out_valid_q;
    logic                   unused_strb;

    always_comb begin
        ctrl       = '0;
        ctrl.qa_m1 = qa_m1_i;
        ctrl.qw_m1 = qw_m1_i;
        ctrl.n_kin = n_kin_i;
        ctrl.n_out = n_out_i;
        ctrl.start = start_i;
    end

    assign load = ctrl.start && (flags_q.state == IDLE);

    // The last beat of a pixel may only be taken if the holding register is
    // free or is being emptied in the same cycle.
    assign pres_ready = (flags_q.state == ACCUM) && enable_i &&
                        !(last_beat && out_valid_q && !accum_o.ready);
    assign pres_hs    = pres_i.valid && pres_ready;

    assign shifted = ACC_WIDTH'(pres_i.data) << shift;
    assign sum     = (first_beat ? '0 : acc_q) + shifted;

    assign pres_i.ready  = pres_ready;
    assign accum_o.valid = out_valid_q;
    assign accum_o.data  = out_data_q;
    assign accum_o.strb  = '1;
    assign busy_o        = flags_q.busy;
    assign done_o        = flags_q.done;
    assign unused_strb   = ^pres_i.strb;

    rbe_accum_idx_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) i_idx_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .load_i       (load),
        .advance_i    (pres_hs),
        .qa_m1_i      (ctrl.qa_m1),
        .qw_m1_i      (ctrl.qw_m1),
        .n_kin_i      (ctrl.n_kin),
        .n_out_i      (ctrl.n_out),
        .first_beat_o (first_beat),
        .last_beat_o  (last_beat),
        .last_job_o   (last_job),
        .shift_o      (shift)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '{busy: 1'b0, done: 1'b0, state: IDLE};
        end else if (clear_i) begin
            flags_q <= '{busy: 1'b0, done: 1'b0, state: IDLE};
        end else begin
            flags_q.done <= 1'b0;
            case (flags_q.state)
                IDLE: begin
                    if (ctrl.start) begin
                        flags_q.state <= ACCUM;
                        flags_q.busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (pres_hs && last_job) begin
                        flags_q.state <= WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (out_valid_q && accum_o.ready) begin
                        flags_q.state <= IDLE;
                        flags_q.busy  <= 1'b0;
                        flags_q.done  <= 1'b1;
                    end
                end
                default: begin
                    flags_q.state <= IDLE;
                    flags_q.busy  <= 1'b0;
                end
            endcase
        end
    end

    // A last beat that arrives while the old result is being consumed
    // refills the register in the same cycle, so valid never bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clear_i) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (pres_hs) begin
                acc_q <= sum;
            end
            if (pres_hs && last_beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sum;
            end else if (out_valid_q && accum_o.ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
